// File: rtl/mips_ex_pkg.sv
// Shared encodings for the MIPS execute stage: ALU control codes, main-control
// ALU op values and R-type funct field values.
// Pure constants and a helper; no logic, no latency, no flow control.
package mips_ex_pkg;

  // Decoded ALU control codes; codes not listed here make the ALU output 0.
  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SLL  = 4'b0011;
  localparam logic [3:0] CTRL_SRL  = 4'b0100;
  localparam logic [3:0] CTRL_SRA  = 4'b0101;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_XOR  = 4'b1000;
  localparam logic [3:0] CTRL_SLTU = 4'b1001;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;
  localparam logic [3:0] CTRL_LUI  = 4'b1101;

  // ALU op values produced by the main control unit.
  localparam logic [3:0] ALUOP_ADD   = 4'b0000;
  localparam logic [3:0] ALUOP_SUB   = 4'b0001;
  localparam logic [3:0] ALUOP_RTYPE = 4'b0010;
  localparam logic [3:0] ALUOP_AND   = 4'b0011;
  localparam logic [3:0] ALUOP_OR    = 4'b0100;
  localparam logic [3:0] ALUOP_SLT   = 4'b0101;
  localparam logic [3:0] ALUOP_XOR   = 4'b0110;
  localparam logic [3:0] ALUOP_LUI   = 4'b0111;

  // R-type funct field values (instruction[5:0]).
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  // Branch target: word offset scaled to bytes, wrapping modulo 2^32.
  function automatic logic [31:0] branch_addr(input logic [31:0] pc_plus4,
                                              input logic [31:0] imm_ext);
    return pc_plus4 + (imm_ext << 2);
  endfunction

endpackage

// File: rtl/mips_alu_ctrl.sv
// ALU control decoder: maps main-control alu_op and R-type funct to alu_ctrl/jr.
// Latency: purely combinational.
// Backpressure: none; evaluates continuously.
// Ports: alu_op[3:0], funct[5:0] in; alu_ctrl[3:0], jr out.
module mips_alu_ctrl
  import mips_ex_pkg::*;
(
  input  logic [3:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       jr
);

  logic [3:0] rtype_ctrl;

  // R-type funct decode; jr is a pass-through ADD so the ALU forwards rs.
  always_comb begin
    rtype_ctrl = CTRL_ADD;
    case (funct)
      F_ADD, F_ADDU: rtype_ctrl = CTRL_ADD;
      F_SUB, F_SUBU: rtype_ctrl = CTRL_SUB;
      F_AND:         rtype_ctrl = CTRL_AND;
      F_OR:          rtype_ctrl = CTRL_OR;
      F_XOR:         rtype_ctrl = CTRL_XOR;
      F_NOR:         rtype_ctrl = CTRL_NOR;
      F_SLT:         rtype_ctrl = CTRL_SLT;
      F_SLTU:        rtype_ctrl = CTRL_SLTU;
      F_SLL:         rtype_ctrl = CTRL_SLL;
      F_SRL:         rtype_ctrl = CTRL_SRL;
      F_SRA:         rtype_ctrl = CTRL_SRA;
      F_JR:          rtype_ctrl = CTRL_ADD;
      default:       rtype_ctrl = CTRL_ADD;
    endcase
  end

  always_comb begin
    alu_ctrl = CTRL_ADD;
    jr       = 1'b0;
    case (alu_op)
      ALUOP_ADD:   alu_ctrl = CTRL_ADD;
      ALUOP_SUB:   alu_ctrl = CTRL_SUB;
      ALUOP_RTYPE: begin
        alu_ctrl = rtype_ctrl;
        jr       = (funct == F_JR);
      end
      ALUOP_AND:   alu_ctrl = CTRL_AND;
      ALUOP_OR:    alu_ctrl = CTRL_OR;
      ALUOP_SLT:   alu_ctrl = CTRL_SLT;
      ALUOP_XOR:   alu_ctrl = CTRL_XOR;
      ALUOP_LUI:   alu_ctrl = CTRL_LUI;
      default:     alu_ctrl = CTRL_ADD;
    endcase
  end

endmodule

// File: rtl/mips_ex_unit.sv
// Execute stage: ALU control decode, 32-bit ALU with shifts, branch-target adder.
// Latency: 1 cycle, all outputs registered; a new result every cycle.
// Backpressure: none; inputs sampled on every rising Clock edge, no stall.
// Ports: Clock, Reset (async active-high); alu_op, funct, shamt, src_a, src_b,
//        imm_ext, pc_plus4 in; alu_result, zero, alu_ctrl, jr, branch_target out.
module mips_ex_unit
  import mips_ex_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [3:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] imm_ext,
  input  logic [31:0] pc_plus4,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [3:0]  alu_ctrl,
  output logic        jr,
  output logic [31:0] branch_target
);

  logic [3:0]  ctrl_d;
  logic        jr_d;
  logic [31:0] result_d;
  logic [31:0] target_d;

  mips_alu_ctrl u_alu_ctrl (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_ctrl (ctrl_d),
    .jr       (jr_d)
  );

  // Shifts operate on src_b (rt) by shamt; src_a is ignored for them.
  always_comb begin
    result_d = 32'h0;
    case (ctrl_d)
      CTRL_AND:  result_d = src_a & src_b;
      CTRL_OR:   result_d = src_a | src_b;
      CTRL_ADD:  result_d = src_a + src_b;
      CTRL_SUB:  result_d = src_a - src_b;
      CTRL_XOR:  result_d = src_a ^ src_b;
      CTRL_NOR:  result_d = ~(src_a | src_b);
      CTRL_SLT:  result_d = {31'h0, $signed(src_a) < $signed(src_b)};
      CTRL_SLTU: result_d = {31'h0, src_a < src_b};
      CTRL_SLL:  result_d = src_b << shamt;
      CTRL_SRL:  result_d = src_b >> shamt;
      CTRL_SRA:  result_d = $signed(src_b) >>> shamt;
      CTRL_LUI:  result_d = {src_b[15:0], 16'h0};
      default:   result_d = 32'h0;
    endcase
  end

  // Adder runs every cycle; PC-select logic decides whether to use it.
  assign target_d = branch_addr(pc_plus4, imm_ext);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      alu_result    <= 32'h0;
      zero          <= 1'b0;
      alu_ctrl      <= 4'h0;
      jr            <= 1'b0;
      branch_target <= 32'h0;
    end else begin
      alu_result    <= result_d;
      zero          <= (result_d == 32'h0);
      alu_ctrl      <= ctrl_d;
      jr            <= jr_d;
      branch_target <= target_d;
    end
  end

endmodule

// File: tb/tb_mips_ex_unit.sv
// Directed bench for mips_ex_unit with a queue-based scoreboard of expectations.
module tb_mips_ex_unit;

  logic        Clock;
  logic        Reset;
  logic [3:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] imm_ext;
  logic [31:0] pc_plus4;
  logic [31:0] alu_result;
  logic        zero;
  logic [3:0]  alu_ctrl;
  logic        jr;
  logic [31:0] branch_target;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        z;
    logic [3:0]  ctrl;
    logic        j;
    logic [31:0] bt;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  mips_ex_unit dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .alu_op        (alu_op),
    .funct         (funct),
    .shamt         (shamt),
    .src_a         (src_a),
    .src_b         (src_b),
    .imm_ext       (imm_ext),
    .pc_plus4      (pc_plus4),
    .alu_result    (alu_result),
    .zero          (zero),
    .alu_ctrl      (alu_ctrl),
    .jr            (jr),
    .branch_target (branch_target)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".alu_result"}, alu_result, 32'h0);
    chk({tag, ".zero"}, {31'h0, zero}, 32'h0);
    chk({tag, ".alu_ctrl"}, {28'h0, alu_ctrl}, 32'h0);
    chk({tag, ".jr"}, {31'h0, jr}, 32'h0);
    chk({tag, ".branch_target"}, branch_target, 32'h0);
  endtask

  // Drive one instruction's operands and queue what must appear after the edge.
  task automatic drive(input string tag, input logic [3:0] op, input logic [5:0] f,
                       input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] pc,
                       input logic [31:0] e_res, input logic e_z, input logic [3:0] e_ctrl,
                       input logic e_j, input logic [31:0] e_bt);
    exp_t e;
    alu_op   = op;
    funct    = f;
    shamt    = sh;
    src_a    = a;
    src_b    = b;
    imm_ext  = imm;
    pc_plus4 = pc;
    e.tag = tag; e.res = e_res; e.z = e_z; e.ctrl = e_ctrl; e.j = e_j; e.bt = e_bt;
    sb.push_back(e);
  endtask

  task automatic tick_check();
    exp_t e;
    @(posedge Clock);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1 entries");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".alu_result"}, alu_result, e.res);
      chk({e.tag, ".zero"}, {31'h0, zero}, {31'h0, e.z});
      chk({e.tag, ".alu_ctrl"}, {28'h0, alu_ctrl}, {28'h0, e.ctrl});
      chk({e.tag, ".jr"}, {31'h0, jr}, {31'h0, e.j});
      chk({e.tag, ".branch_target"}, branch_target, e.bt);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] op, input logic [5:0] f,
                      input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] imm, input logic [31:0] pc,
                      input logic [31:0] e_res, input logic e_z, input logic [3:0] e_ctrl,
                      input logic e_j, input logic [31:0] e_bt);
    drive(tag, op, f, sh, a, b, imm, pc, e_res, e_z, e_ctrl, e_j, e_bt);
    tick_check();
  endtask

  initial begin
    Reset = 1'b1;
    alu_op = 4'h0; funct = 6'h0; shamt = 5'h0;
    src_a = 32'h0; src_b = 32'h0; imm_ext = 32'h0; pc_plus4 = 32'h0;
    #2;
    chk_all_zero("por");
    @(posedge Clock);
    #3;
    Reset = 1'b0;
    #1;
    chk_all_zero("por_release");

    // Main function; non-zero pc values make the target register visibly move.
    //   tag          op     funct  sh  src_a         src_b         imm_ext       pc_plus4
    step("sub_r",    4'h2, 6'h22, 5'd0, 32'd5,        32'd7,        32'h0, 32'h00000100,
         32'hFFFFFFFE, 1'b0, 4'b0110, 1'b0, 32'h00000100);
    step("beq",      4'h1, 6'h00, 5'd0, 32'h1234,     32'h1234,     32'h0, 32'h00000104,
         32'h0, 1'b1, 4'b0110, 1'b0, 32'h00000104);
    step("sra",      4'h2, 6'h03, 5'd4, 32'hDEADBEEF, 32'h80000000, 32'h0, 32'h00000108,
         32'hF8000000, 1'b0, 4'b0101, 1'b0, 32'h00000108);
    step("sll",      4'h2, 6'h00, 5'd31, 32'h0,       32'h1,        32'h0, 32'h0000010C,
         32'h80000000, 1'b0, 4'b0011, 1'b0, 32'h0000010C);
    step("srl",      4'h2, 6'h02, 5'd4, 32'h0,        32'h80000000, 32'h0, 32'h00000110,
         32'h08000000, 1'b0, 4'b0100, 1'b0, 32'h00000110);
    step("slt",      4'h2, 6'h2A, 5'd0, 32'hFFFFFFFF, 32'h1,        32'h0, 32'h0,
         32'h1, 1'b0, 4'b0111, 1'b0, 32'h0);
    step("sltu",     4'h2, 6'h2B, 5'd0, 32'hFFFFFFFF, 32'h1,        32'h0, 32'h0,
         32'h0, 1'b1, 4'b1001, 1'b0, 32'h0);
    step("nor",      4'h2, 6'h27, 5'd0, 32'h0,        32'h0,        32'h0, 32'h0,
         32'hFFFFFFFF, 1'b0, 4'b1100, 1'b0, 32'h0);
    step("jr",       4'h2, 6'h08, 5'd0, 32'h00400100, 32'h0,        32'h0, 32'h0,
         32'h00400100, 1'b0, 4'b0010, 1'b1, 32'h0);
    step("add_f08",  4'h0, 6'h08, 5'd0, 32'd3,        32'd4,        32'h0, 32'h0,
         32'd7, 1'b0, 4'b0010, 1'b0, 32'h0);
    step("lui",      4'h7, 6'h00, 5'd0, 32'h12345678, 32'h5555ABCD, 32'h0, 32'h0,
         32'hABCD0000, 1'b0, 4'b1101, 1'b0, 32'h0);
    step("ori",      4'h4, 6'h00, 5'd0, 32'hF0,       32'h0F,       32'h0, 32'h0,
         32'hFF, 1'b0, 4'b0001, 1'b0, 32'h0);
    step("andi",     4'h3, 6'h00, 5'd0, 32'hF0,       32'h3C,       32'h0, 32'h0,
         32'h30, 1'b0, 4'b0000, 1'b0, 32'h0);
    step("xori",     4'h6, 6'h00, 5'd0, 32'hFF,       32'h0F,       32'h0, 32'h0,
         32'hF0, 1'b0, 4'b1000, 1'b0, 32'h0);
    step("slti",     4'h5, 6'h00, 5'd0, 32'h1,        32'hFFFFFFFF, 32'h0, 32'h0,
         32'h0, 1'b1, 4'b0111, 1'b0, 32'h0);
    step("op_other", 4'hF, 6'h22, 5'd0, 32'd1,        32'd2,        32'h0, 32'h0,
         32'd3, 1'b0, 4'b0010, 1'b0, 32'h0);
    step("f_other",  4'h2, 6'h3F, 5'd0, 32'd10,       32'd20,       32'h0, 32'h0,
         32'd30, 1'b0, 4'b0010, 1'b0, 32'h0);
    step("addu_wrap", 4'h2, 6'h21, 5'd0, 32'hFFFFFFFF, 32'h1,       32'h0, 32'h0,
         32'h0, 1'b1, 4'b0010, 1'b0, 32'h0);
    step("bt_neg",   4'h1, 6'h00, 5'd0, 32'd9,        32'd8,        32'hFFFFFFFF, 32'h00400004,
         32'h1, 1'b0, 4'b0110, 1'b0, 32'h00400000);
    step("bt_wrap",  4'h0, 6'h00, 5'd0, 32'd0,        32'd0,        32'h2, 32'hFFFFFFFC,
         32'h0, 1'b1, 4'b0010, 1'b0, 32'h00000004);

    // Reset mid-stream: registered result of bt_wrap is discarded at once,
    // outputs stay 0 after release until the next edge captures live inputs.
    drive("post_rst", 4'h2, 6'h08, 5'd0, 32'h00400200, 32'h0, 32'h1, 32'h00001000,
          32'h00400200, 1'b0, 4'b0010, 1'b1, 32'h00001004);
    #1;
    Reset = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    #3;
    Reset = 1'b0;
    #1;
    chk_all_zero("rst_release");
    tick_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_ex_unit.md
# mips_ex_unit

Execute-stage datapath block for the single-issue MIPS core. It combines three functions: ALU-control decode of the 4-bit main-control ALU op and the R-type funct field, a 32-bit ALU with shift support, and the branch-target adder. All results are captured in one output register stage so they feed the memory/write-back and PC-select logic one cycle later.

## Interface
- No parameters; widths fixed at 32-bit data, 5-bit shamt, 4-bit ALU op/ctrl.
- Clock  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-high; clears all output registers.
- alu_op  in  4  ALU op from main control.
- funct  in  6  instruction[5:0].
- shamt  in  5  instruction[10:6].
- src_a  in  32  register read data 1 (rs).
- src_b  in  32  ALU operand B (rt, or the extended immediate after the src mux).
- imm_ext  in  32  sign/zero-extended immediate.
- pc_plus4  in  32  PC+4 of the current instruction.
- alu_result  out  32  registered ALU result.
- zero  out  1  registered, high when the ALU result is 0.
- alu_ctrl  out  4  registered decoded ALU control.
- jr  out  1  registered jump-register flag.
- branch_target  out  32  registered value of pc_plus4 + (imm_ext << 2).

## Operation
- alu_op decode:
  - 0000 → ADD (lw/sw/addi)
  - 0001 → SUB (beq/bne)
  - 0010 → R-type, use funct
  - 0011 → AND (andi)
  - 0100 → OR (ori)
  - 0101 → SLT (slti)
  - 0110 → XOR (xori)
  - 0111 → LUI
  - Any other alu_op decodes to ADD.
- funct decode (R-type only):
  - 0x20 and 0x21 → ADD
  - 0x22 and 0x23 → SUB
  - 0x24 → AND; 0x25 → OR; 0x26 → XOR; 0x27 → NOR
  - 0x2A → SLT; 0x2B → SLTU
  - 0x00 → SLL; 0x02 → SRL; 0x03 → SRA
  - 0x08 → jr=1 with ctrl ADD
  - Any other funct → ADD with jr=0.
- jr is 1 only when alu_op=0010 and funct=0x08.
- alu_ctrl codes:
  - AND 0000, OR 0001, ADD 0010, SLL 0011, SRL 0100, SRA 0101
  - SUB 0110, SLT 0111, XOR 1000, SLTU 1001, NOR 1100, LUI 1101
  - Unused codes produce result 0.
- ALU function:
  - ADD and SUB wrap modulo 2^32; no overflow trap.
  - SLT is a signed compare, SLTU unsigned; both give {31'b0, a<b}.
  - Shifts use src_b as the shifted value and shamt as the amount; src_a is ignored. SRA is arithmetic.
  - LUI result is {src_b[15:0], 16'b0}.
  - zero is 1 when the 32-bit result is 0.
- Branch target: pc_plus4 + {imm_ext[29:0], 2'b00}, wrapping modulo 2^32. It is computed every cycle regardless of alu_op.

## Timing
- Decode, ALU and adder are purely combinational. All five outputs are registered on the rising Clock edge: 1-cycle latency, a new result every cycle, no handshake.
- Reset asserted (async): alu_result=0, zero=0, alu_ctrl=0000, jr=0, branch_target=0 immediately. Outputs hold these values until the first rising edge after Reset deasserts.
- Reset taking effect mid-stream discards the in-flight result. There is no stall or enable; inputs are sampled every edge.

## Structure
- Shared package mips_ex_pkg holds the alu_ctrl localparams (CTRL_AND … CTRL_LUI), the alu_op encodings, and the funct constants (F_ADD, F_JR, …).
- One sub-module, mips_alu_ctrl: the combinational decoder from alu_op and funct to alu_ctrl and jr.
- ALU, branch adder and output register sit in the top.

## Test plan
- Reset mid-run: assert Reset between edges → all outputs 0 at once. Deassert Reset → outputs stay 0 until the next edge.
- R-type: alu_op=0010, funct=0x22, src_a=5, src_b=7 → one edge later alu_result=0xFFFFFFFE, zero=0, alu_ctrl=0110.
- beq-style compare: alu_op=0001, src_a=src_b=0x1234 → zero=1, alu_result=0.
- Shifts:
  - funct=0x03, src_b=0x80000000, shamt=4 → 0xF8000000.
  - funct=0x00, src_b=1, shamt=31 → 0x80000000.
- Compare, logic and jr:
  - slt with a=-1, b=1 → 1.
  - sltu with the same operands → 0.
  - funct=0x27, a=b=0 → 0xFFFFFFFF.
  - funct=0x08 → jr=1.
  - alu_op=0000 with funct=0x08 → jr=0.
- Branch target:
  - pc_plus4=0x00400004, imm_ext=0xFFFFFFFF → 0x00400000.
  - pc_plus4=0xFFFFFFFC, imm_ext=2 → 0x00000004 (wrap).
